gpio_iomem_arbiter: RTL and testbench

- Two-requester round-robin arbiter sharing the single iomem-style register port of the GPIO controller.
- Typical requesters: m0 = management CPU wishbone adapter, m1 = housekeeping/debug master.
- Holds each grant until the slave returns a ready pulse, then rotates priority.
- Sits between the masters and the GPIO controller's iomem_* port; the slave side is unchanged.

---
 rtl/gpio_arb_pkg.sv | 17 +
 rtl/gpio_rr_arb2.sv | 22 ++
 rtl/gpio_iomem_arbiter.sv | 156 +++++++++++++++
 tb/tb_gpio_iomem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the GPIO iomem arbiter.
// Optional timeout logic in the top level is enabled by GPIO_ARB_TIMEOUT_EN.
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_e;

    // Read data handed back to a master whose access timed out
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

    // Width of the BUSY-cycle timeout counter (covers TIMEOUT_CYCLES up to 255)
    localparam int unsigned TO_CNT_W = 8;

endpackage

// File: rtl/gpio_rr_arb2.sv
// Combinational two-way round-robin picker.
// A lone request wins outright; on a tie the requester that was not served
// last wins.
module gpio_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       any
);

    // One-hot grant selection with rotating priority on a tie
    always_comb begin
        gnt = '0;
        any = |req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/gpio_iomem_arbiter.sv
// Two-master round-robin arbiter in front of the GPIO controller iomem port.
// A grant is held until the slave pulses s_ready (or the master drops valid),
// then priority rotates to the other master.
// Define GPIO_ARB_TIMEOUT_EN to force an error completion after
// TIMEOUT_CYCLES BUSY cycles without a slave ready.
module gpio_iomem_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic [31:0] m0_addr,
    input  logic        m0_valid,
    input  logic        m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,

    input  logic [31:0] m1_addr,
    input  logic        m1_valid,
    input  logic        m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,

    output logic [31:0] s_addr,
    output logic        s_valid,
    output logic        s_wstrb,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,

    output logic [1:0]  grant
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("gpio_iomem_arbiter: TIMEOUT_CYCLES must be within 2..255");
    end

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [1:0] pick_gnt;
    logic       pick_any;
    logic       timeout_hit;

    gpio_rr_arb2 u_pick (
        .req  ({m1_valid, m0_valid}),
        .last (last_grant_q),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

`ifdef GPIO_ARB_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

    // Count consecutive unacknowledged BUSY cycles; zero whenever IDLE
    always_comb begin
        to_cnt_d = '0;
        if (state_q != IDLE && state_d != IDLE) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout_hit = (state_q != IDLE) && !s_ready && (to_cnt_q == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // State and priority registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state: arbitrate in IDLE, release on completion, abort or timeout
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    if (pick_gnt[0]) begin
                        state_d = BUSY0;
                    end else if (pick_gnt[1]) begin
                        state_d = BUSY1;
                    end
                end
            end
            BUSY0: begin
                if (s_ready || timeout_hit || !m0_valid) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            BUSY1: begin
                if (s_ready || timeout_hit || !m1_valid) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: route the owner to the slave and its completion back
    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wstrb  = 1'b0;
        s_wdata  = '0;
        grant    = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = timeout_hit ? ERR_RDATA : s_rdata;
        m1_rdata = timeout_hit ? ERR_RDATA : s_rdata;
        case (state_q)
            BUSY0: begin
                s_valid  = m0_valid;
                s_addr   = m0_addr;
                s_wstrb  = m0_wstrb;
                s_wdata  = m0_wdata;
                grant    = 2'b01;
                m0_ready = s_ready || timeout_hit;
            end
            BUSY1: begin
                s_valid  = m1_valid;
                s_addr   = m1_addr;
                s_wstrb  = m1_wstrb;
                s_wdata  = m1_wdata;
                grant    = 2'b10;
                m1_ready = s_ready || timeout_hit;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gpio_iomem_arbiter.sv
// Directed self-checking bench for gpio_iomem_arbiter.
// Inputs change and outputs are sampled at the falling clock edge.
module tb_gpio_iomem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m0_valid, m0_wstrb, m0_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_valid, m1_wstrb, m1_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_valid, s_wstrb, s_ready;
    logic [1:0]  grant;

    logic        slave_en;
    logic [31:0] slave_rdata;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    gpio_iomem_arbiter #(
        .TIMEOUT_CYCLES (16),
        .ERR_RDATA      (32'hFFFF_FFFF)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .m0_addr  (m0_addr),
        .m0_valid (m0_valid),
        .m0_wstrb (m0_wstrb),
        .m0_wdata (m0_wdata),
        .m0_rdata (m0_rdata),
        .m0_ready (m0_ready),
        .m1_addr  (m1_addr),
        .m1_valid (m1_valid),
        .m1_wstrb (m1_wstrb),
        .m1_wdata (m1_wdata),
        .m1_rdata (m1_rdata),
        .m1_ready (m1_ready),
        .s_addr   (s_addr),
        .s_valid  (s_valid),
        .s_wstrb  (s_wstrb),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata),
        .s_ready  (s_ready),
        .grant    (grant)
    );

    // GPIO controller stand-in: registered one-cycle ready with !ready guard
    always @(posedge clk) begin
        if (!resetn) s_ready <= 1'b0;
        else         s_ready <= s_valid && !s_ready && slave_en;
    end
    assign s_rdata = slave_rdata;

    task automatic apply_reset();
        resetn   = 1'b0;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        m0_addr  = 32'h2100_0010;
        repeat (3) @(negedge clk);
        total++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b expected 00", grant); else passed++;
        total++; if (s_valid !== 1'b0) $display("FAIL reset_s_valid: got %b expected 0", s_valid); else passed++;
        total++; if (m0_ready !== 1'b0) $display("FAIL reset_m0_ready: got %b expected 0", m0_ready); else passed++;
        total++; if (m1_ready !== 1'b0) $display("FAIL reset_m1_ready: got %b expected 0", m1_ready); else passed++;
        total++; if (s_addr !== 32'h0) $display("FAIL reset_s_addr: got %h expected 0", s_addr); else passed++;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        resetn   = 1'b1;
        @(negedge clk);
        total++; if (grant !== 2'b00) $display("FAIL idle_grant: got %b expected 00", grant); else passed++;
    endtask

    task automatic test_write();
        int m0_cnt = 0;
        int m1_cnt = 0;
        int ready_at = -1;
        m0_addr  = 32'h2100_0000;
        m0_wstrb = 1'b1;
        m0_wdata = 32'h0000_0001;
        m0_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                total++; if (grant !== 2'b01) $display("FAIL write_grant: got %b expected 01", grant); else passed++;
                total++; if (s_valid !== 1'b1) $display("FAIL write_s_valid: got %b expected 1", s_valid); else passed++;
                total++; if (s_addr !== 32'h2100_0000) $display("FAIL write_s_addr: got %h expected 21000000", s_addr); else passed++;
                total++; if (s_wstrb !== 1'b1) $display("FAIL write_s_wstrb: got %b expected 1", s_wstrb); else passed++;
                total++; if (s_wdata !== 32'h1) $display("FAIL write_s_wdata: got %h expected 00000001", s_wdata); else passed++;
            end
            if (m0_ready === 1'b1) begin
                m0_cnt++;
                if (ready_at < 0) ready_at = i;
                m0_valid = 1'b0;
            end
            if (m1_ready === 1'b1) m1_cnt++;
        end
        total++; if (ready_at != 2) $display("FAIL write_latency: got cycle %0d expected 2", ready_at); else passed++;
        total++; if (m0_cnt != 1) $display("FAIL write_m0_pulses: got %0d expected 1", m0_cnt); else passed++;
        total++; if (m1_cnt != 0) $display("FAIL write_m1_pulses: got %0d expected 0", m1_cnt); else passed++;
        total++; if (grant !== 2'b00) $display("FAIL write_idle_after: got %b expected 00", grant); else passed++;
    endtask

    task automatic test_tie();
        logic [1:0] glog [1:6];
        int m0_at = -1;
        int m1_at = -1;
        apply_reset();
        m0_wstrb = 1'b0;
        m1_wstrb = 1'b0;
        m0_addr  = 32'h2100_0004;
        m1_addr  = 32'h2100_0008;
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            glog[i] = grant;
            if (m0_ready === 1'b1) begin if (m0_at < 0) m0_at = i; m0_valid = 1'b0; end
            if (m1_ready === 1'b1) begin if (m1_at < 0) m1_at = i; m1_valid = 1'b0; end
        end
        total++; if (glog[1] !== 2'b01) $display("FAIL tie_grant1: got %b expected 01", glog[1]); else passed++;
        total++; if (glog[3] !== 2'b00) $display("FAIL tie_grant_idle: got %b expected 00", glog[3]); else passed++;
        total++; if (glog[4] !== 2'b10) $display("FAIL tie_grant2: got %b expected 10", glog[4]); else passed++;
        total++; if (m0_at != 2) $display("FAIL tie_m0_ready: got cycle %0d expected 2", m0_at); else passed++;
        total++; if (m1_at != 5) $display("FAIL tie_m1_ready: got cycle %0d expected 5", m1_at); else passed++;
    endtask

    task automatic test_back_to_back();
        int order [6];
        int n = 0;
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        for (int i = 1; i <= 40 && n < 6; i++) begin
            @(negedge clk);
            if (m0_ready === 1'b1 && n < 6) begin order[n] = 0; n++; end
            if (m1_ready === 1'b1 && n < 6) begin order[n] = 1; n++; end
            if (n == 6) begin m0_valid = 1'b0; m1_valid = 1'b0; end
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        total++; if (n != 6) $display("FAIL b2b_count: got %0d expected 6", n); else passed++;
        for (int k = 0; k < n; k++) begin
            total++;
            if (order[k] != (k % 2)) $display("FAIL b2b_order[%0d]: got m%0d expected m%0d", k, order[k], k % 2);
            else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_read_m1();
        logic       seen = 1'b0;
        logic [31:0] rd = '0;
        logic       other = 1'b0;
        logic [1:0] g = '0;
        slave_rdata = 32'h0000_0002;
        m1_addr  = 32'h2100_000C;
        m1_wstrb = 1'b0;
        m1_valid = 1'b1;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(negedge clk);
            if (m1_ready === 1'b1) begin
                seen = 1'b1;
                rd = m1_rdata;
                other = m0_ready;
                g = grant;
                m1_valid = 1'b0;
            end
        end
        total++; if (seen !== 1'b1) $display("FAIL read_m1_ready: got %b expected 1", seen); else passed++;
        total++; if (rd !== 32'h0000_0002) $display("FAIL read_m1_rdata: got %h expected 00000002", rd); else passed++;
        total++; if (other !== 1'b0 || g !== 2'b10) $display("FAIL read_m1_owner: got m0_ready=%b grant=%b expected 0/10", other, g); else passed++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic seen = 1'b0;
        int   m0r = 0;
        slave_en = 1'b0;
        m0_addr  = 32'h2100_0008;
        m0_wstrb = 1'b0;
        m0_valid = 1'b1;
        @(negedge clk);
        total++; if (grant !== 2'b01) $display("FAIL abort_busy0: got %b expected 01", grant); else passed++;
        m0_valid = 1'b0;
        m1_valid = 1'b1;
        @(negedge clk);
        total++; if (grant !== 2'b00 || m0_ready !== 1'b0) $display("FAIL abort_idle: got grant=%b m0_ready=%b expected 00/0", grant, m0_ready); else passed++;
        @(negedge clk);
        total++; if (grant !== 2'b10) $display("FAIL abort_m1_grant: got %b expected 10", grant); else passed++;
        slave_en = 1'b1;
        for (int i = 1; i <= 6 && !seen; i++) begin
            @(negedge clk);
            if (m0_ready === 1'b1) m0r++;
            if (m1_ready === 1'b1) begin seen = 1'b1; m1_valid = 1'b0; end
        end
        m1_valid = 1'b0;
        total++; if (seen !== 1'b1) $display("FAIL abort_m1_done: got %b expected 1", seen); else passed++;
        total++; if (m0r != 0) $display("FAIL abort_m0_ready: got %0d pulses expected 0", m0r); else passed++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        slave_en = 1'b0;
        m0_addr  = 32'h3000_0000;
        m0_wstrb = 1'b0;
        m0_valid = 1'b1;
`ifdef GPIO_ARB_TIMEOUT_EN
        begin
            int first = -1;
            logic [31:0] rd = '0;
            for (int i = 1; i <= 30; i++) begin
                @(negedge clk);
                if (m0_ready === 1'b1 && first < 0) begin
                    first = i;
                    rd = m0_rdata;
                    m0_valid = 1'b0;
                end
            end
            m0_valid = 1'b0;
            total++; if (first != 16) $display("FAIL timeout_cycle: got %0d expected 16", first); else passed++;
            total++; if (rd !== 32'hFFFF_FFFF) $display("FAIL timeout_rdata: got %h expected ffffffff", rd); else passed++;
        end
`else
        begin
            int bad = 0;
            int m0r = 0;
            for (int i = 1; i <= 100; i++) begin
                @(negedge clk);
                if (grant !== 2'b01) bad++;
                if (m0_ready === 1'b1) m0r++;
            end
            total++; if (bad != 0) $display("FAIL hold_busy0: got %0d non-BUSY0 cycles expected 0", bad); else passed++;
            total++; if (m0r != 0) $display("FAIL hold_m0_ready: got %0d pulses expected 0", m0r); else passed++;
            m0_valid = 1'b0;
        end
`endif
        @(negedge clk);
        total++; if (grant !== 2'b00) $display("FAIL timeout_idle: got %b expected 00", grant); else passed++;
        slave_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        slave_en = 1'b1;
        m0_addr  = 32'h2100_0000;
        m0_wstrb = 1'b1;
        m0_wdata = 32'h0000_0003;
        m0_valid = 1'b1;
        @(negedge clk);
        total++; if (grant !== 2'b01) $display("FAIL rmid_busy: got %b expected 01", grant); else passed++;
        resetn = 1'b0;
        @(negedge clk);
        total++; if (grant !== 2'b00) $display("FAIL rmid_grant: got %b expected 00", grant); else passed++;
        total++; if (s_valid !== 1'b0) $display("FAIL rmid_s_valid: got %b expected 0", s_valid); else passed++;
        total++; if (m0_ready !== 1'b0) $display("FAIL rmid_m0_ready: got %b expected 0", m0_ready); else passed++;
        resetn = 1'b1;
        for (int i = 1; i <= 6 && !seen; i++) begin
            @(negedge clk);
            if (m0_ready === 1'b1) begin seen = 1'b1; m0_valid = 1'b0; end
        end
        m0_valid = 1'b0;
        total++; if (seen !== 1'b1) $display("FAIL rmid_retry: got %b expected 1", seen); else passed++;
        @(negedge clk);
    endtask

    initial begin
        resetn      = 1'b0;
        m0_addr     = '0;
        m0_valid    = 1'b0;
        m0_wstrb    = 1'b0;
        m0_wdata    = '0;
        m1_addr     = '0;
        m1_valid    = 1'b0;
        m1_wstrb    = 1'b0;
        m1_wdata    = '0;
        slave_en    = 1'b1;
        slave_rdata = 32'h0000_0000;

        test_reset();
        test_write();
        test_tie();
        test_back_to_back();
        test_read_m1();
        test_abort();
        test_timeout();
        test_reset_mid();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
